// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus shared by the requesters and the register-file write port.
// The requester side drives valid/rd/wd and observes ready plus the
// registered register-file write; the arbiter side is the reverse.
interface rf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_wd;
  logic               rf_wr;
  logic [AW-1:0]      rf_a3;
  logic [DW-1:0]      rf_wd;

  modport master (
    output req_valid, req_rd, req_wd,
    input  req_ready, rf_wr, rf_a3, rf_wd
  );

  modport slave (
    input  req_valid, req_rd, req_wd,
    output req_ready, rf_wr, rf_a3, rf_wd
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a
// pending-write scoreboard so decode can stall on RAW/WAW hazards until the
// register file really holds a result.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_arbiter_if.slave    wb,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [AW-1:0]     chk_a1,
  input  logic [AW-1:0]     chk_a2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              iss_conflict,
  output logic              pend_any
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 1 << AW;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            rf_wr_q, rf_wr_d;
  logic [AW-1:0]   rf_a3_q, rf_a3_d;
  logic [DW-1:0]   rf_wd_q, rf_wd_d;
  logic [NREG-1:0] pend_q, pend_d;

  logic [NREQ-1:0] gnt_s;
  logic [PW-1:0]   gidx_s;
  logic            found_s;
  logic            hs_s;
  logic [AW-1:0]   sel_rd_s;
  logic [DW-1:0]   sel_wd_s;
  int              idx_s;

  // Pick the first valid requester scanning upward from rr_ptr with wrap.
  always_comb begin
    gnt_s   = '0;
    gidx_s  = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = (int'(rr_ptr_q) + k) % NREQ;
      if (!found_s && wb.req_valid[idx_s]) begin
        found_s       = 1'b1;
        gnt_s[idx_s]  = 1'b1;
        gidx_s        = PW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grants are suppressed during reset; an in-flight request is dropped.
  always_comb begin
    if (rst) begin
      wb.req_ready = '0;
      hs_s         = 1'b0;
    end else begin
      wb.req_ready = gnt_s;
      hs_s         = found_s;
    end
  end

  assign sel_rd_s = wb.req_rd[gidx_s*AW +: AW];
  assign sel_wd_s = wb.req_wd[gidx_s*DW +: DW];

  // Next pointer and next register-file write; rd=0 is accepted but never written.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rf_wr_d  = 1'b0;
    rf_a3_d  = rf_a3_q;
    rf_wd_d  = rf_wd_q;
    if (hs_s) begin
      rr_ptr_d = (gidx_s == PW'(NREQ - 1)) ? '0 : gidx_s + PW'(1);
      rf_wr_d  = (sel_rd_s != '0);
      rf_a3_d  = sel_rd_s;
      rf_wd_d  = sel_wd_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Scoreboard: clear on the register-file write edge, then set from issue so
  // a newer producer of the same register wins; x0 is never tracked.
  always_comb begin
    pend_d = pend_q;
    if (rf_wr_q) begin
      pend_d[rf_a3_q] = 1'b0;
    end else begin
      pend_d = pend_d;
    end
    if (iss_valid && (iss_rd != '0)) begin
      pend_d[iss_rd] = 1'b1;
    end else begin
      pend_d = pend_d;
    end
    pend_d[0] = 1'b0;
  end

  // State registers; write-port outputs clear the moment reset asserts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      rf_wr_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd_q  <= '0;
      pend_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rf_wr_q  <= rf_wr_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd_q  <= rf_wd_d;
      pend_q   <= pend_d;
    end
  end

  assign wb.rf_wr = rf_wr_q;
  assign wb.rf_a3 = rf_a3_q;
  assign wb.rf_wd = rf_wd_q;

  assign hazard1      = (chk_a1 != '0) & pend_q[chk_a1];
  assign hazard2      = (chk_a2 != '0) & pend_q[chk_a2];
  assign iss_conflict = (iss_rd != '0) & pend_q[iss_rd];
  assign pend_any     = |pend_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench: a per-cycle vector table for arbitration, write timing and
// scoreboard behaviour, plus hand-written reset sequences.
module tb_rf_wb_arbiter;

  logic       clk;
  logic       rst;
  logic       iss_valid;
  logic [4:0] iss_rd;
  logic [4:0] chk_a1;
  logic [4:0] chk_a2;
  logic       hazard1;
  logic       hazard2;
  logic       iss_conflict;
  logic       pend_any;

  int total = 0;
  int bad   = 0;

  rf_wb_arbiter_if #(.NREQ(3), .AW(5), .DW(32)) bus ();

  rf_wb_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb           (bus),
    .iss_valid    (iss_valid),
    .iss_rd       (iss_rd),
    .chk_a1       (chk_a1),
    .chk_a2       (chk_a2),
    .hazard1      (hazard1),
    .hazard2      (hazard2),
    .iss_conflict (iss_conflict),
    .pend_any     (pend_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  rd0, rd1, rd2;
    logic [31:0] wd0, wd1, wd2;
    logic        iv;
    logic [4:0]  ird, a1, a2;
    logic [2:0]  e_rdy;
    logic        e_wr;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_h1, e_h2, e_cf, e_pa;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [2:0] v, input logic [4:0] rd0, input logic [4:0] rd1, input logic [4:0] rd2,
    input logic [31:0] wd0, input logic [31:0] wd1, input logic [31:0] wd2,
    input logic iv, input logic [4:0] ird, input logic [4:0] a1, input logic [4:0] a2,
    input logic [2:0] e_rdy, input logic e_wr, input logic [4:0] e_a3, input logic [31:0] e_wd,
    input logic e_h1, input logic e_h2, input logic e_cf, input logic e_pa);
    vec_t t;
    t.v = v; t.rd0 = rd0; t.rd1 = rd1; t.rd2 = rd2;
    t.wd0 = wd0; t.wd1 = wd1; t.wd2 = wd2;
    t.iv = iv; t.ird = ird; t.a1 = a1; t.a2 = a2;
    t.e_rdy = e_rdy; t.e_wr = e_wr; t.e_a3 = e_a3; t.e_wd = e_wd;
    t.e_h1 = e_h1; t.e_h2 = e_h2; t.e_cf = e_cf; t.e_pa = e_pa;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  localparam logic [31:0] WA  = 32'hDEAD_BEEF;
  localparam logic [31:0] X1  = 32'h0BAD_0001;
  localparam logic [31:0] X2  = 32'h0BAD_0002;
  localparam logic [31:0] W1  = 32'h1111_0001;
  localparam logic [31:0] W2  = 32'h2222_0002;
  localparam logic [31:0] W3  = 32'h3333_0003;
  localparam logic [31:0] W4  = 32'h4444_0004;
  localparam logic [31:0] W7  = 32'h7777_0007;
  localparam logic [31:0] W9  = 32'h9999_0009;
  localparam logic [31:0] W9B = 32'h9B9B_0009;
  localparam logic [31:0] Z   = 32'h0000_0000;

  logic [2:0]  pend_m;
  logic [14:0] prev_rd;
  logic [95:0] prev_wd;

  initial begin
    // Columns: v rd0 rd1 rd2 wd0 wd1 wd2 iv ird a1 a2 | rdy wr a3 wd h1 h2 cf pa
    vecs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, Z,  Z,  Z,  1'b0, 5'd0,  5'd0, 5'd0,  3'b000, 1'b0, 5'd0, Z,   1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b001, 5'd5, 5'd0, 5'd0, WA, Z,  Z,  1'b0, 5'd0,  5'd0, 5'd0,  3'b001, 1'b0, 5'd0, Z,   1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, Z,  Z,  Z,  1'b0, 5'd0,  5'd0, 5'd0,  3'b000, 1'b1, 5'd5, WA,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b010, 5'd0, 5'd0, 5'd0, Z,  X1, Z,  1'b0, 5'd0,  5'd0, 5'd0,  3'b010, 1'b0, 5'd5, WA,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b100, 5'd0, 5'd0, 5'd0, Z,  Z,  X2, 1'b0, 5'd0,  5'd0, 5'd0,  3'b100, 1'b0, 5'd0, X1,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, W1, W2, W3, 1'b0, 5'd0,  5'd0, 5'd0,  3'b001, 1'b0, 5'd0, X2,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, W1, W2, W3, 1'b0, 5'd0,  5'd0, 5'd0,  3'b010, 1'b1, 5'd1, W1,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, W1, W2, W3, 1'b0, 5'd0,  5'd0, 5'd0,  3'b100, 1'b1, 5'd2, W2,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, W1, W2, W3, 1'b0, 5'd0,  5'd0, 5'd0,  3'b001, 1'b1, 5'd3, W3,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, W1, W2, W3, 1'b0, 5'd0,  5'd0, 5'd0,  3'b010, 1'b1, 5'd1, W1,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, W1, W2, W3, 1'b0, 5'd0,  5'd0, 5'd0,  3'b100, 1'b1, 5'd2, W2,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b011, 5'd1, 5'd2, 5'd3, W1, W2, W3, 1'b0, 5'd0,  5'd0, 5'd0,  3'b001, 1'b1, 5'd3, W3,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b010, 5'd1, 5'd2, 5'd3, W1, W2, W3, 1'b0, 5'd0,  5'd0, 5'd0,  3'b010, 1'b1, 5'd1, W1,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, Z,  Z,  Z,  1'b0, 5'd0,  5'd0, 5'd0,  3'b000, 1'b1, 5'd2, W2,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, Z,  Z,  Z,  1'b0, 5'd0,  5'd1, 5'd3,  3'b000, 1'b0, 5'd2, W2,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, Z,  Z,  Z,  1'b1, 5'd7,  5'd7, 5'd0,  3'b000, 1'b0, 5'd2, W2,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b010, 5'd0, 5'd7, 5'd0, Z,  W7, Z,  1'b0, 5'd0,  5'd7, 5'd0,  3'b010, 1'b0, 5'd2, W2,  1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, Z,  Z,  Z,  1'b0, 5'd0,  5'd7, 5'd0,  3'b000, 1'b1, 5'd7, W7,  1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, Z,  Z,  Z,  1'b0, 5'd0,  5'd7, 5'd0,  3'b000, 1'b0, 5'd7, W7,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b001, 5'd9, 5'd0, 5'd0, W9, Z,  Z,  1'b1, 5'd9,  5'd9, 5'd7,  3'b001, 1'b0, 5'd7, W7,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, Z,  Z,  Z,  1'b1, 5'd9,  5'd9, 5'd0,  3'b000, 1'b1, 5'd9, W9,  1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(3'b010, 5'd0, 5'd9, 5'd0, Z,  W9B,Z,  1'b0, 5'd0,  5'd9, 5'd0,  3'b010, 1'b0, 5'd9, W9,  1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, Z,  Z,  Z,  1'b1, 5'd10, 5'd9, 5'd10, 3'b000, 1'b1, 5'd9, W9B, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, Z,  Z,  Z,  1'b0, 5'd0,  5'd9, 5'd10, 3'b000, 1'b0, 5'd9, W9B, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, Z,  Z,  Z,  1'b1, 5'd4,  5'd0, 5'd0,  3'b000, 1'b0, 5'd9, W9B, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, Z,  Z,  Z,  1'b1, 5'd4,  5'd4, 5'd10, 3'b000, 1'b0, 5'd9, W9B, 1'b1, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, Z,  Z,  Z,  1'b1, 5'd0,  5'd0, 5'd0,  3'b000, 1'b0, 5'd9, W9B, 1'b0, 1'b0, 1'b0, 1'b1));

    // Power-on reset with requests presented: no grant, write port cleared.
    rst = 1'b1;
    bus.req_valid = 3'b111;
    bus.req_rd = {5'd3, 5'd2, 5'd1};
    bus.req_wd = {W3, W2, W1};
    iss_valid = 1'b0; iss_rd = 5'd0; chk_a1 = 5'd0; chk_a2 = 5'd0;
    #1;
    chk("por rdy", {29'd0, bus.req_ready}, 32'd0);
    chk("por rf_wr", {31'd0, bus.rf_wr}, 32'd0);
    chk("por rf_a3", {27'd0, bus.rf_a3}, 32'd0);
    chk("por rf_wd", bus.rf_wd, 32'd0);
    @(negedge clk);
    bus.req_valid = 3'b000;
    rst = 1'b0;
    @(posedge clk); #1;

    pend_m = 3'b000; prev_rd = '0; prev_wd = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.req_valid = vecs[i].v;
      bus.req_rd    = {vecs[i].rd2, vecs[i].rd1, vecs[i].rd0};
      bus.req_wd    = {vecs[i].wd2, vecs[i].wd1, vecs[i].wd0};
      iss_valid     = vecs[i].iv;
      iss_rd        = vecs[i].ird;
      chk_a1        = vecs[i].a1;
      chk_a2        = vecs[i].a2;
      for (int r = 0; r < 3; r++) begin
        if (pend_m[r]) begin
          assert (bus.req_valid[r] && bus.req_rd[r*5 +: 5] == prev_rd[r*5 +: 5]
                  && bus.req_wd[r*32 +: 32] == prev_wd[r*32 +: 32])
            else $error("requester %0d changed its request before handshake (row %0d)", r, i);
        end
      end
      @(negedge clk);
      chk($sformatf("row%0d rdy", i),   {29'd0, bus.req_ready}, {29'd0, vecs[i].e_rdy});
      chk($sformatf("row%0d rf_wr", i), {31'd0, bus.rf_wr},     {31'd0, vecs[i].e_wr});
      chk($sformatf("row%0d rf_a3", i), {27'd0, bus.rf_a3},     {27'd0, vecs[i].e_a3});
      chk($sformatf("row%0d rf_wd", i), bus.rf_wd,              vecs[i].e_wd);
      chk($sformatf("row%0d haz1", i),  {31'd0, hazard1},       {31'd0, vecs[i].e_h1});
      chk($sformatf("row%0d haz2", i),  {31'd0, hazard2},       {31'd0, vecs[i].e_h2});
      chk($sformatf("row%0d waw", i),   {31'd0, iss_conflict},  {31'd0, vecs[i].e_cf});
      chk($sformatf("row%0d pend", i),  {31'd0, pend_any},      {31'd0, vecs[i].e_pa});
      pend_m  = bus.req_valid & ~bus.req_ready;
      prev_rd = bus.req_rd;
      prev_wd = bus.req_wd;
      @(posedge clk); #1;
    end

    // Mid-cycle reset while a write is on the port and a request is active.
    iss_valid = 1'b0; iss_rd = 5'd0; chk_a1 = 5'd0; chk_a2 = 5'd0;
    bus.req_valid = 3'b001;
    bus.req_rd = {5'd0, 5'd0, 5'd4};
    bus.req_wd = {Z, Z, W4};
    @(negedge clk);
    chk("pre-rst rdy", {29'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("pre-rst rf_wr", {31'd0, bus.rf_wr}, 32'd1);
    chk("pre-rst rf_a3", {27'd0, bus.rf_a3}, 32'd4);
    chk("pre-rst rf_wd", bus.rf_wd, W4);
    #2 rst = 1'b1;
    #1;
    chk("rst rf_wr", {31'd0, bus.rf_wr}, 32'd0);
    chk("rst rf_a3", {27'd0, bus.rf_a3}, 32'd0);
    chk("rst rf_wd", bus.rf_wd, 32'd0);
    chk("rst rdy", {29'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst hold rdy", {29'd0, bus.req_ready}, 32'd0);
    chk("rst hold rf_wr", {31'd0, bus.rf_wr}, 32'd0);
    bus.req_valid = 3'b000;
    rst = 1'b0;
    @(posedge clk); #1;

    // Scoreboard is empty for every address after reset.
    for (int a = 0; a < 32; a++) begin
      chk_a1 = 5'(a);
      chk_a2 = 5'(31 - a);
      #1;
      chk($sformatf("post-rst haz1 a=%0d", a), {31'd0, hazard1}, 32'd0);
      chk($sformatf("post-rst haz2 a=%0d", a), {31'd0, hazard2}, 32'd0);
    end
    chk("post-rst pend", {31'd0, pend_any}, 32'd0);

    // Issuing to x0 never creates a pending entry.
    iss_valid = 1'b1; iss_rd = 5'd0;
    @(posedge clk); #1;
    iss_valid = 1'b0;
    chk("x0 iss pend", {31'd0, pend_any}, 32'd0);

    // Pointer restarts at requester 0 after reset.
    bus.req_valid = 3'b111;
    bus.req_rd = {5'd3, 5'd2, 5'd1};
    bus.req_wd = {W3, W2, W1};
    #1;
    chk("post-rst rr", {29'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("post-rst rf_a3", {27'd0, bus.rf_a3}, 32'd1);
    chk("post-rst rf_wd", bus.rf_wd, W1);
    bus.req_valid = 3'b000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (write enable, write address, write data) between NREQ writeback requesters: ALU, load unit, multi-cycle mul/div.
- Arbitrates round-robin with a valid/ready handshake per requester.
- Registers the winning write toward the register file.
- Keeps a pending-write scoreboard for x1..x31 so decode can stall on RAW/WAW hazards until the register file actually holds the result.

Parameters:
- NREQ, 3, number of writeback requesters (2..4).
- AW, 5, register address width.
- DW, 32, write data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester grant; handshake = valid & ready.
- req_rd  in  NREQ*AW  destination register, requester i at bits [i*AW +: AW].
- req_wd  in  NREQ*DW  write data, requester i at bits [i*DW +: DW].
- rf_wr  out  1  register-file write enable (registered).
- rf_a3  out  AW  register-file write address (registered).
- rf_wd  out  DW  register-file write data (registered).
- iss_valid  in  1  an instruction with a pending destination is issued.
- iss_rd  in  AW  destination of the issued instruction.
- chk_a1  in  AW  source 1 address to check.
- chk_a2  in  AW  source 2 address to check.
- hazard1  out  1  chk_a1 has a pending write.
- hazard2  out  1  chk_a2 has a pending write.
- iss_conflict  out  1  iss_rd already pending (WAW); decode must hold issue.
- pend_any  out  1  at least one pending bit set.

Behaviour:
- Reset (async):
  - rr_ptr=0 and pend[31:1]=0.
  - rf_wr=0, rf_a3=0, rf_wd=0 take effect immediately, not at the next edge.
  - req_ready=0 while rst is high.
  - An in-flight request is dropped; its requester re-presents it after reset.
- Arbitration (combinational, each cycle):
  - Scan requesters starting at rr_ptr, wrapping modulo NREQ.
  - The first one with valid high gets ready=1; all others get 0.
  - At most one ready bit is high. No valid means all ready=0.
- Pointer update:
  - On a handshake by requester g, rr_ptr <= (g+1) mod NREQ.
  - With no handshake, rr_ptr holds.
  - A continuously valid requester is served within NREQ cycles.
- Requester rule: once valid is high, valid, rd and wd stay stable until the handshake. The arbiter does not check this; the bench asserts it.
- Write output timing:
  - On a handshake edge, rf_wr<=(rd!=0), rf_a3<=rd, rf_wd<=wd.
  - With no handshake, rf_wr<=0 and rf_a3/rf_wd hold.
  - Latency is 1 cycle from handshake to rf_wr high. The register file writes on the following edge.
  - Throughput is one write per cycle.
- rd=0: the request is accepted (ready given, pointer advances), rf_wr stays 0, and the scoreboard is untouched.
- Scoreboard:
  - Set: on an edge with iss_valid & iss_rd!=0, pend[iss_rd]<=1.
  - Clear: on an edge with rf_wr=1 (the register-file write edge), pend[rf_a3]<=0.
  - Same register set and cleared on one edge: set wins (newer producer).
  - Different registers set and cleared on one edge: both take effect.
- Hazard and status outputs (combinational):
  - hazardN = (chk_aN!=0) & pend[chk_aN].
  - iss_conflict = (iss_rd!=0) & pend[iss_rd].
  - pend_any = |pend.
  - x0 never reads as pending.
- Unsolicited writeback: a writeback to a register that is not pending is legal. It is written and leaves pend at 0.

Test Plan:
- Reset: rst pulse mid-cycle with reqs active -> rf_wr=0 and req_ready=0 immediately; after release, hazard1=hazard2=pend_any=0 for all chk addresses.
- Single write: req0 valid rd=5 wd=32'hDEADBEEF at cycle t -> req_ready[0]=1 at t; rf_wr=1, rf_a3=5, rf_wd=DEADBEEF at t+1; rf_wr=0 at t+2.
- Round-robin: all 3 valid continuously with rd=1,2,3 -> grants 0,1,2,0,1,2; rf_a3 sequence 1,2,3,1,2,3 on consecutive cycles.
- Scoreboard: iss rd=7, chk_a1=7 -> hazard1=1 next cycle; req1 writes rd=7 -> hazard1 stays 1 through the rf_wr cycle, 0 the cycle after.
- Set/clear collision: rf_wr=1 rf_a3=9 on the same edge as iss rd=9 -> pend[9] stays 1, hazard on 9 persists; with iss rd=10 instead -> pend[9]=0, pend[10]=1.
- x0 and WAW: req with rd=0 -> handshake, rf_wr stays 0; iss rd=0 -> pend_any=0; iss rd=4 twice -> iss_conflict=1 on the second.
